fire9_squeeze_ofm_writer: RTL and testbench
===========================================

# fire9_squeeze_ofm_writer

Receive side of the fire9 squeeze output interface. Captures each DSP_NO-channel output pixel vector presented with the one-cycle `sample` strobe, buffers it in a two-slot ping-pong store, and serializes it into single-word writes to the activation RAM that feeds fire9 expand. After the last pixel of the WOUT×WOUT map is written, it pulses `ram_feedback_o` back to the squeeze layer.

## Interface
Parameters:
- `WOUT`, 8: output map side length; pixels per layer = WOUT**2.
- `DSP_NO`, 112: channels per pixel vector.
- `WIDTH`, 16: word width.
- `ADDR_W`, $clog2(WOUT**2*DSP_NO): RAM address width (13 at defaults).

Ports:
- `clk`, in, 1: clock; all logic is rising-edge.
- `rst`, in, 1: **reset is asynchronous and active-high.**
- `sample_i`, in, 1: one-cycle strobe; `ofm_i` is valid in this cycle.
- `ofm_i`, in, [WIDTH-1:0] x [0:DSP_NO-1]: unpacked output pixel vector.
- `ram_we_o`, out, 1: RAM write enable.
- `ram_addr_o`, out, ADDR_W: write address = pixel*DSP_NO + channel.
- `ram_data_o`, out, WIDTH: write data.
- `ram_feedback_o`, out, 1: one-cycle pulse when the full map has been written.
- `busy_o`, out, 1: high while either slot holds data.
- `overflow_o`, out, 1: sticky; a sample was dropped because both slots were full.

## Operation
- Slot store: 2 × DSP_NO × WIDTH. wr_slot and rd_slot are 1-bit pointers; occ counts slots holding data (0..2).
- Capture: when `sample_i` is high and accepted, copy all of `ofm_i` into wr_slot, toggle wr_slot, increment occ.
- Accept rule:
  - accept if occ<2, or if occ==2 and the last word of the active slot is written in the same cycle;
  - otherwise drop the sample, set `overflow_o`, leave pix_cnt unchanged.
- Drain FSM states:
  - IDLE: entered from reset. Moves to DRAIN when occ>0.
  - DRAIN: writes channel ch_cnt=0..DSP_NO-1 of rd_slot, one word per cycle. At ch_cnt==DSP_NO-1:
    - toggle rd_slot, decrement occ, increment pix_cnt;
    - if pix_cnt becomes WOUT**2, go to DONE;
    - else if another slot is occupied (including one captured this cycle), stay in DRAIN with ch_cnt=0;
    - else go to IDLE.
  - DONE: pulse `ram_feedback_o` for exactly one cycle on entry, then hold until `rst`. Later samples are ignored: no write, no overflow.
- Capture and drain-complete in the same cycle leave occ unchanged.
- Address: pix_cnt*DSP_NO + ch_cnt, computed from a running base register incremented by DSP_NO per pixel. No multiplier.
- Extra samples beyond WOUT**2 (the squeeze timer can emit one more) are discarded silently.

## Timing
- Reset values: `ram_we_o`=0, `ram_addr_o`=0, `ram_data_o`=0, `ram_feedback_o`=0, `busy_o`=0, `overflow_o`=0. Internally: pointers 0, occ 0, pix_cnt 0, FSM in IDLE.
- Outputs are registered.
- Sample accepted at edge t (from IDLE): words appear with `ram_we_o` high on cycles t+1 … t+DSP_NO, addresses consecutive.
- Back-to-back pixels: the next slot's first word follows the previous slot's last word with zero gap.
- `ram_feedback_o` is high in the cycle after the final word (pixel WOUT**2-1, channel DSP_NO-1).
- `busy_o` rises the cycle after capture and falls the cycle after the last word of the final occupied slot.
- Nominal squeeze cadence is 513 cycles per pixel, so normal operation never uses the second slot for more than DSP_NO cycles.
- `rst` asserted mid-drain: writes abort immediately and the block returns to reset values. The partially written pixel is not completed.

## Configuration
- `FIRE9_WRITER_CHECKSUM_EN` defined:
  - adds output `checksum_o` [WIDTH-1:0], a wrap-around sum of every written `ram_data_o`;
  - the sum is frozen when `ram_feedback_o` pulses and cleared by `rst`.
- Undefined: the port and the adder are absent; all other behaviour is identical.

## Structure
- Shared package `fire_pkg`:
  - word typedef `word_t` (logic [WIDTH-1:0]);
  - `writer_state_t` enum {IDLE, DRAIN, DONE};
  - constants for DSP_NO, WIDTH, WOUT.
- One sub-module, `fire_ofm_pingpong`: the two-slot store with its pointers, occ, and the accept/overflow logic. It exposes a word-indexed read port.
- The top module holds the FSM, counters, address base, and the optional checksum.

## Test plan
- Single pixel: reset, then `sample_i` with ofm_i[c]=c+1 → `ram_we_o` high for 112 cycles, addr 0..111, data 1..112; `busy_o` then returns to 0.
- Full map at 513-cycle cadence, pixel p channel c = p*256+c → 7168 writes, addr = data-decoded index, `ram_feedback_o` pulses once after addr 7167; a 65th sample causes no write and no overflow.
- Back-to-back samples at t and t+1 → 224 contiguous writes, addresses 0..223, `overflow_o` stays 0.
- Three samples at t, t+1, t+2 → third dropped, `overflow_o`=1, exactly 224 writes.
- Sample coinciding with the last word of a full slot pair → accepted, no overflow, writes continue gap-free.
- `rst` pulsed at channel 50 of pixel 3 → `ram_we_o` low next cycle; a following sample writes from addr 0. With `FIRE9_WRITER_CHECKSUM_EN` defined, `checksum_o` returns to 0.

Source files
------------

// File: rtl/fire_pkg.sv
// Shared types and default geometry for the fire9 squeeze -> expand activation path.
package fire_pkg;

  localparam int FIRE9_WOUT   = 8;
  localparam int FIRE9_DSP_NO = 112;
  localparam int FIRE9_WIDTH  = 16;

  typedef logic [FIRE9_WIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } writer_state_t;

endpackage

// File: rtl/fire_ofm_pingpong.sv
// Two-slot ping-pong store for squeeze output pixel vectors, with accept/overflow control
// and a word-indexed read port on the slot currently being drained.
module fire_ofm_pingpong #(
  parameter int DSP_NO = 112,
  parameter int WIDTH  = 16,
  parameter int CH_W   = $clog2(DSP_NO)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] ofm_i [0:DSP_NO-1],
  input  logic             block_i,
  input  logic             drain_done_i,
  input  logic [CH_W-1:0]  rd_idx_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             accept_o,
  output logic [1:0]       occ_o,
  output logic             overflow_o
);

  logic [WIDTH-1:0] mem_q [0:1][0:DSP_NO-1];
  logic [WIDTH-1:0] mem_d [0:1][0:DSP_NO-1];
  logic             wr_slot_q, wr_slot_d;
  logic             rd_slot_q, rd_slot_d;
  logic [1:0]       occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic             offered_s;
  logic             accept_s;

  // A full pair may still take a sample when the draining slot frees up this very cycle.
  always_comb begin
    offered_s  = sample_i & ~block_i;
    accept_s   = offered_s & ((occ_q != 2'd2) | drain_done_i);
    mem_d      = mem_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    occ_d      = occ_q;
    overflow_d = overflow_q;
    if (accept_s) begin
      for (int c = 0; c < DSP_NO; c++) begin
        mem_d[wr_slot_q][c] = ofm_i[c];
      end
      wr_slot_d = ~wr_slot_q;
    end else begin
      wr_slot_d = wr_slot_q;
    end
    if (drain_done_i) begin
      rd_slot_d = ~rd_slot_q;
    end else begin
      rd_slot_d = rd_slot_q;
    end
    case ({accept_s, drain_done_i})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
    if (offered_s & ~accept_s) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Pixel data store; contents are qualified by occ, so no reset is needed.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Slot pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot_q  <= 1'b0;
      rd_slot_q  <= 1'b0;
      occ_q      <= 2'd0;
      overflow_q <= 1'b0;
    end else begin
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      occ_q      <= occ_d;
      overflow_q <= overflow_d;
    end
  end

  assign rd_data_o  = mem_q[rd_slot_q][rd_idx_i];
  assign accept_o   = accept_s;
  assign occ_o      = occ_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/fire9_squeeze_ofm_writer.sv
// fire9 squeeze OFM writer: serializes buffered pixel vectors into activation RAM writes.
// Optional running checksum output enabled by FIRE9_WRITER_CHECKSUM_EN.
module fire9_squeeze_ofm_writer
  import fire_pkg::*;
#(
  parameter int WOUT   = FIRE9_WOUT,
  parameter int DSP_NO = FIRE9_DSP_NO,
  parameter int WIDTH  = FIRE9_WIDTH,
  parameter int ADDR_W = $clog2(WOUT*WOUT*DSP_NO)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_i,
  input  logic [WIDTH-1:0]  ofm_i [0:DSP_NO-1],
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [WIDTH-1:0]  ram_data_o,
  output logic              ram_feedback_o,
  output logic              busy_o,
  output logic              overflow_o
`ifdef FIRE9_WRITER_CHECKSUM_EN
  ,
  output logic [WIDTH-1:0]  checksum_o
`endif
);

  localparam int CH_W  = $clog2(DSP_NO);
  localparam int PIX_W = $clog2(WOUT*WOUT+1);
  localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(DSP_NO-1);
  localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(WOUT*WOUT-1);
  localparam logic [ADDR_W-1:0] PIX_STRIDE = ADDR_W'(DSP_NO);

  writer_state_t     state_q, state_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [PIX_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              ram_we_q, ram_we_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0]  ram_data_q, ram_data_d;
  logic              feedback_q, feedback_d;
  logic              fb_sent_q, fb_sent_d;
  logic              busy_q, busy_d;
  logic              active_s, last_s, final_s, block_s, accept_s;
  logic [1:0]        occ_s;
  logic [WIDTH-1:0]  rd_data_s;
`ifdef FIRE9_WRITER_CHECKSUM_EN
  logic [WIDTH-1:0]  checksum_q, checksum_d;
`endif

  fire_ofm_pingpong #(
    .DSP_NO (DSP_NO),
    .WIDTH  (WIDTH),
    .CH_W   (CH_W)
  ) u_pingpong (
    .clk          (clk),
    .rst          (rst),
    .sample_i     (sample_i),
    .ofm_i        (ofm_i),
    .block_i      (block_s),
    .drain_done_i (last_s),
    .rd_idx_i     (ch_cnt_q),
    .rd_data_o    (rd_data_s),
    .accept_o     (accept_s),
    .occ_o        (occ_s),
    .overflow_o   (overflow_o)
  );

  // Issue one word per cycle while a slot is held; the final pixel also closes the input.
  always_comb begin
    active_s   = (state_q != DONE) & (occ_s != 2'd0);
    last_s     = active_s & (ch_cnt_q == LAST_CH);
    final_s    = last_s & (pix_cnt_q == LAST_PIX);
    block_s    = (state_q == DONE) | final_s;
    state_d    = state_q;
    ch_cnt_d   = ch_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    base_d     = base_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_we_d   = active_s;
    busy_d     = (occ_s != 2'd0);
    feedback_d = (state_q == DONE) & ~fb_sent_q;
    fb_sent_d  = fb_sent_q | (state_q == DONE);
    case (state_q)
      DONE: state_d = DONE;
      IDLE, DRAIN: begin
        if (final_s) begin
          state_d = DONE;
        end else if (last_s) begin
          state_d = ((occ_s == 2'd2) | accept_s) ? DRAIN : IDLE;
        end else if (active_s) begin
          state_d = DRAIN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (active_s) begin
      ram_addr_d = base_q + ADDR_W'(ch_cnt_q);
      ram_data_d = rd_data_s;
      ch_cnt_d   = last_s ? {CH_W{1'b0}} : ch_cnt_q + CH_W'(1);
    end else begin
      ch_cnt_d   = ch_cnt_q;
    end
    if (last_s) begin
      pix_cnt_d = pix_cnt_q + PIX_W'(1);
      base_d    = base_q + PIX_STRIDE;
    end else begin
      pix_cnt_d = pix_cnt_q;
      base_d    = base_q;
    end
  end

`ifdef FIRE9_WRITER_CHECKSUM_EN
  // Sum of words already presented to the RAM; stops moving once the map is complete.
  always_comb begin
    if (ram_we_q) begin
      checksum_d = checksum_q + ram_data_q;
    end else begin
      checksum_d = checksum_q;
    end
  end
`endif

  // Writer FSM, counters and registered RAM-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_cnt_q   <= {CH_W{1'b0}};
      pix_cnt_q  <= {PIX_W{1'b0}};
      base_q     <= {ADDR_W{1'b0}};
      ram_we_q   <= 1'b0;
      ram_addr_q <= {ADDR_W{1'b0}};
      ram_data_q <= {WIDTH{1'b0}};
      feedback_q <= 1'b0;
      fb_sent_q  <= 1'b0;
      busy_q     <= 1'b0;
`ifdef FIRE9_WRITER_CHECKSUM_EN
      checksum_q <= {WIDTH{1'b0}};
`endif
    end else begin
      state_q    <= state_d;
      ch_cnt_q   <= ch_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      base_q     <= base_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      feedback_q <= feedback_d;
      fb_sent_q  <= fb_sent_d;
      busy_q     <= busy_d;
`ifdef FIRE9_WRITER_CHECKSUM_EN
      checksum_q <= checksum_d;
`endif
    end
  end

  assign ram_we_o       = ram_we_q;
  assign ram_addr_o     = ram_addr_q;
  assign ram_data_o     = ram_data_q;
  assign ram_feedback_o = feedback_q;
  assign busy_o         = busy_q;
`ifdef FIRE9_WRITER_CHECKSUM_EN
  assign checksum_o     = checksum_q;
`endif

endmodule

// File: tb/tb_fire9_squeeze_ofm_writer.sv
// Scoreboard bench for fire9_squeeze_ofm_writer: stimulus pushes expected RAM writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_fire9_squeeze_ofm_writer;

  typedef struct packed {
    logic [12:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_i;
  logic [15:0] ofm [0:111];
  logic        ram_we_o;
  logic [12:0] ram_addr_o;
  logic [15:0] ram_data_o;
  logic        ram_feedback_o;
  logic        busy_o;
  logic        overflow_o;
`ifdef FIRE9_WRITER_CHECKSUM_EN
  logic [15:0] checksum_o;
`endif

  wr_t exp_q [$];
  int  checks = 0;
  int  failures = 0;
  int  mon_checks = 0;
  int  mon_fail = 0;
  int  fb_count = 0;
  bit  prev_we = 1'b0;
  logic [12:0] prev_addr = 13'd0;

  always #5 clk = ~clk;

  fire9_squeeze_ofm_writer dut (
    .clk            (clk),
    .rst            (rst),
    .sample_i       (sample_i),
    .ofm_i          (ofm),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_data_o     (ram_data_o),
    .ram_feedback_o (ram_feedback_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o)
`ifdef FIRE9_WRITER_CHECKSUM_EN
    ,
    .checksum_o     (checksum_o)
`endif
  );

  // Monitor: every write must match the head of the scoreboard, streams must be gap-free.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (ram_we_o) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          mon_fail++;
          $display("FAIL unexpected_write addr=%0d data=%0d required=no_write", ram_addr_o, ram_data_o);
        end else begin
          e = exp_q.pop_front();
          if (ram_addr_o !== e.addr || ram_data_o !== e.data) begin
            mon_fail++;
            $display("FAIL write addr=%0d data=%0d required addr=%0d data=%0d",
                     ram_addr_o, ram_data_o, e.addr, e.data);
          end
        end
      end else if (prev_we && exp_q.size() != 0) begin
        mon_checks++;
        mon_fail++;
        $display("FAIL write_gap after addr=%0d pending=%0d required=0 gap", prev_addr, exp_q.size());
      end
      if (ram_feedback_o) begin
        fb_count++;
        mon_checks++;
        if (!(prev_we && prev_addr == 13'd7167)) begin
          mon_fail++;
          $display("FAIL feedback_timing prev_we=%0d prev_addr=%0d required prev_we=1 prev_addr=7167",
                   prev_we, prev_addr);
        end
      end
      prev_we   = ram_we_o;
      prev_addr = ram_addr_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic load_ofm(input int base);
    for (int c = 0; c < 112; c++) ofm[c] = 16'(base + c);
  endtask

  task automatic expect_pixel(input int pix, input int base);
    wr_t e;
    for (int c = 0; c < 112; c++) begin
      e.addr = 13'(pix * 112 + c);
      e.data = 16'(base + c);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse;
    sample_i = 1'b1;
    tick(1);
    sample_i = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    sample_i = 1'b0;
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(5);
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_addr(input int a, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ram_we_o && ram_addr_o == 13'(a)) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_addr", 32'(ok), 32'd1);
  endtask

  initial begin
    int fb_before;
    rst = 1'b1;
    sample_i = 1'b0;
    load_ofm(0);
    tick(3);
    check("rst_we", 32'(ram_we_o), 32'd0);
    check("rst_addr", 32'(ram_addr_o), 32'd0);
    check("rst_data", 32'(ram_data_o), 32'd0);
    check("rst_feedback", 32'(ram_feedback_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);

    // Single pixel, data c+1
    do_reset();
    load_ofm(1);
    expect_pixel(0, 1);
    pulse();
    tick(1);
    check("single_busy_high", 32'(busy_o), 32'd1);
    wait_drain(300);
    check("single_busy_low", 32'(busy_o), 32'd0);
    check("single_overflow", 32'(overflow_o), 32'd0);
`ifdef FIRE9_WRITER_CHECKSUM_EN
    check("single_checksum", 32'(checksum_o), 32'd6328);
`endif

    // Back-to-back samples
    do_reset();
    sample_i = 1'b1;
    load_ofm(0);
    expect_pixel(0, 0);
    tick(1);
    load_ofm(256);
    expect_pixel(1, 256);
    tick(1);
    sample_i = 1'b0;
    wait_drain(600);
    check("b2b_overflow", 32'(overflow_o), 32'd0);
    check("b2b_busy", 32'(busy_o), 32'd0);

    // Three samples: third is dropped
    do_reset();
    sample_i = 1'b1;
    load_ofm(0);
    expect_pixel(0, 0);
    tick(1);
    load_ofm(256);
    expect_pixel(1, 256);
    tick(1);
    load_ofm(512);
    tick(1);
    sample_i = 1'b0;
    wait_drain(600);
    check("drop_overflow", 32'(overflow_o), 32'd1);

    // Sample coinciding with the last word of a full pair
    do_reset();
    sample_i = 1'b1;
    load_ofm(0);
    expect_pixel(0, 0);
    tick(1);
    load_ofm(256);
    expect_pixel(1, 256);
    tick(1);
    sample_i = 1'b0;
    wait_addr(110, 400);
    load_ofm(512);
    expect_pixel(2, 512);
    sample_i = 1'b1;
    @(posedge clk);
    #1;
    sample_i = 1'b0;
    wait_drain(800);
    check("coincide_overflow", 32'(overflow_o), 32'd0);

    // Full map at 513-cycle cadence plus one extra sample
    do_reset();
    fb_before = fb_count;
    for (int p = 0; p < 64; p++) begin
      load_ofm(p * 256);
      expect_pixel(p, p * 256);
      pulse();
      tick(512);
    end
    load_ofm(64 * 256);
    pulse();
    tick(200);
    wait_drain(10);
    check("map_feedback_count", 32'(fb_count - fb_before), 32'd1);
    check("map_overflow", 32'(overflow_o), 32'd0);
    check("map_busy", 32'(busy_o), 32'd0);
    check("map_feedback_low", 32'(ram_feedback_o), 32'd0);

    // Reset mid-drain at channel 50 of pixel 3
    do_reset();
    for (int p = 0; p < 3; p++) begin
      load_ofm(p * 256);
      expect_pixel(p, p * 256);
      pulse();
      wait_drain(300);
    end
    load_ofm(3 * 256);
    expect_pixel(3, 3 * 256);
    pulse();
    wait_addr(3 * 112 + 50, 300);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("abort_we", 32'(ram_we_o), 32'd0);
    check("abort_addr", 32'(ram_addr_o), 32'd0);
    check("abort_busy", 32'(busy_o), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(1);
`ifdef FIRE9_WRITER_CHECKSUM_EN
    check("abort_checksum", 32'(checksum_o), 32'd0);
`endif
    load_ofm(1792);
    expect_pixel(0, 1792);
    pulse();
    wait_drain(300);
    check("restart_overflow", 32'(overflow_o), 32'd0);

    checks   += mon_checks;
    failures += mon_fail;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
